exc_redirect_ctrl: RTL and testbench
====================================

# exc_redirect_ctrl

Sequencer that turns a committed exception or ERET in the MEM stage into an ordered recovery: pipeline flush, bus drain, a single CP0 commit and a single PC redirect. Sits between the MEM-stage exception resolution logic, the CP0 register file, the PC generator and the I/D bus interfaces. It serialises recovery so that CP0 state is written once per event and the PC is redirected only after outstanding bus transactions have finished.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, general exception entry address
- DRAIN_MAX, 255, maximum drain cycles before forced progress (8-bit counter)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- exc_type_i  in  9  one-hot-or-more event vector, bit order: [0] Interrupt, [1] WrongAddressinIF, [2] ReservedInstruction, [3] Syscall, [4] Break, [5] Overflow, [6] WrWrongAddressinMEM, [7] RdWrongAddressinMEM, [8] Eret
- exc_pc_i  in  32  PC of the MEM-stage instruction
- exc_ds_i  in  1  MEM-stage instruction is in a delay slot
- exc_memaddr_i  in  32  data address of the MEM-stage access
- cp0_epc_i  in  32  latest EPC value (WB forwarding already applied)
- ibus_busy_i  in  1  instruction bus has an outstanding transaction
- dbus_busy_i  in  1  data bus has an outstanding transaction
- flush_o  out  4  {MEMWB, EXEMEM, IDEXE, IFID} flush enables
- stall_o  out  1  freeze PC and all pipeline registers
- cp0_exc_we_o  out  1  one-cycle pulse: write EPC, Cause.ExcCode/BD, set Status.EXL
- cp0_eret_o  out  1  one-cycle pulse: clear Status.EXL
- cp0_epc_o  out  32  EPC value to write
- cp0_bd_o  out  1  Cause.BD value
- cp0_exccode_o  out  5  Cause.ExcCode value
- cp0_badvaddr_we_o  out  1  BadVAddr write enable (with cp0_exc_we_o)
- cp0_badvaddr_o  out  32  BadVAddr value
- redirect_valid_o  out  1  one-cycle PC redirect pulse
- redirect_pc_o  out  32  redirect target
- drain_timeout_o  out  1  sticky: a drain exceeded DRAIN_MAX
- busy_o  out  1  state is not IDLE

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE: if exc_type_i != 0, capture the event (pc, ds, memaddr, type); next state DRAIN. exc_type_i == 0 keeps IDLE.
- Priority when several bits are set: bit 0 highest, down to bit 8 (Eret) lowest. Only the winning event is captured. ERET path is taken only when bits [7:0] are all zero.
- ExcCode: Int 0x00, AdEL (bit 1 or 7) 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
- EPC = ds ? pc-4 : pc, modulo 2^32 (pc 0 with ds gives 0xFFFF_FFFC); BD = ds.
- BadVAddr: bit 1 gives pc; bits 6/7 give memaddr; otherwise badvaddr_we_o = 0.
- DRAIN: flush_o = 4'b1111 and stall_o = 1. An 8-bit counter starts at 0. Leave for COMMIT when ibus_busy_i = dbus_busy_i = 0, or when the counter reaches DRAIN_MAX; the latter also sets drain_timeout_o. drain_timeout_o clears only on rst.
- COMMIT (1 cycle): stall_o = 1, flush_o = 0. Exception: cp0_exc_we_o = 1. ERET: cp0_eret_o = 1 and cp0_exc_we_o = 0.
- REDIRECT (1 cycle): redirect_valid_o = 1. redirect_pc_o = EXC_VECTOR for an exception, or cp0_epc_i sampled at entry to REDIRECT for ERET. stall_o = 0. Next state IDLE.
- exc_type_i is ignored in every state except IDLE.
- rst in any state: next state IDLE, counter cleared, capture registers cleared, drain_timeout_o cleared.

## Timing
- All outputs are registered or decoded from the state register. None are combinational from inputs, except redirect_pc_o in the ERET path, which is a registered sample.
- Event sampled at edge N. DRAIN is active in cycle N+1 at the earliest. If both buses are idle in N+1, COMMIT is in N+2, REDIRECT in N+3 and IDLE in N+4. Minimum latency from event to redirect is 3 cycles.
- Busy inputs are sampled each DRAIN cycle. Exit happens on the edge after the first cycle in which both are low.
- Reset values: every output 0, redirect_pc_o 0, cp0_* data 0, state IDLE.
- busy_o = 1 in DRAIN, COMMIT and REDIRECT.

## Test plan
- Syscall, pc=0x8000_1000, ds=0, buses idle: in cycle N+1 flush_o=4'hF; in N+2 cp0_exc_we_o pulse with epc 0x8000_1000, exccode 0x08, bd 0; in N+3 redirect to 0xBFC0_0380.
- Overflow, pc=0x8000_0004, ds=1: epc 0x8000_0000, bd 1, exccode 0x0C. Also pc=0, ds=1: epc 0xFFFF_FFFC.
- RdWrongAddressinMEM with memaddr 0x1234_5671, dbus_busy_i high for 5 cycles: DRAIN lasts 6 cycles; commit gives exccode 0x04, badvaddr 0x1234_5671; drain_timeout_o stays 0.
- ERET with cp0_epc_i=0x8000_2000: cp0_eret_o pulse, no cp0_exc_we_o, redirect 0x8000_2000. Interrupt+Eret together: interrupt path taken, exccode 0x00.
- ibus_busy_i stuck high: exit after DRAIN_MAX; drain_timeout_o=1 and held until rst. A second event during DRAIN is ignored.
- rst asserted during DRAIN: next cycle IDLE, all outputs 0, no commit or redirect pulse.

Source files
------------

// File: rtl/exc_redirect_ctrl_if.sv
// rtl/exc_redirect_ctrl_if.sv - MEM-stage event, CP0, PC-redirect and bus-status signals of the recovery sequencer
interface exc_redirect_ctrl_if;
   logic [8:0]  exc_type_i;
   logic [31:0] exc_pc_i;
   logic        exc_ds_i;
   logic [31:0] exc_memaddr_i;
   logic [31:0] cp0_epc_i;
   logic        ibus_busy_i;
   logic        dbus_busy_i;

   logic [3:0]  flush_o;
   logic        stall_o;
   logic        cp0_exc_we_o;
   logic        cp0_eret_o;
   logic [31:0] cp0_epc_o;
   logic        cp0_bd_o;
   logic [4:0]  cp0_exccode_o;
   logic        cp0_badvaddr_we_o;
   logic [31:0] cp0_badvaddr_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        drain_timeout_o;
   logic        busy_o;

   modport slave (
      input  exc_type_i, exc_pc_i, exc_ds_i, exc_memaddr_i, cp0_epc_i,
             ibus_busy_i, dbus_busy_i,
      output flush_o, stall_o, cp0_exc_we_o, cp0_eret_o, cp0_epc_o, cp0_bd_o,
             cp0_exccode_o, cp0_badvaddr_we_o, cp0_badvaddr_o,
             redirect_valid_o, redirect_pc_o, drain_timeout_o, busy_o
   );

   modport master (
      output exc_type_i, exc_pc_i, exc_ds_i, exc_memaddr_i, cp0_epc_i,
             ibus_busy_i, dbus_busy_i,
      input  flush_o, stall_o, cp0_exc_we_o, cp0_eret_o, cp0_epc_o, cp0_bd_o,
             cp0_exccode_o, cp0_badvaddr_we_o, cp0_badvaddr_o,
             redirect_valid_o, redirect_pc_o, drain_timeout_o, busy_o
   );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// rtl/exc_redirect_ctrl.sv - serialises exception/ERET recovery: flush+drain, one CP0 commit, one PC redirect
module exc_redirect_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [7:0]  DRAIN_MAX  = 8'd255
) (
   input  logic           clk,
   input  logic           rst,
   exc_redirect_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  drain_cnt;
   logic        drain_timeout;
   logic [31:0] redirect_pc;

   logic        cap_eret;
   logic [31:0] cap_epc;
   logic        cap_bd;
   logic [4:0]  cap_code;
   logic        cap_bav_we;
   logic [31:0] cap_bav;

   logic        ev_any;
   logic        ev_eret;
   logic [4:0]  ev_code;
   logic        ev_bav_we;
   logic [31:0] ev_bav;
   logic [31:0] ev_epc;
   logic        bus_idle;
   logic        drain_expired;

   assign ev_any        = |bus.exc_type_i;
   assign ev_epc        = bus.exc_ds_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
   assign bus_idle      = !bus.ibus_busy_i && !bus.dbus_busy_i;
   assign drain_expired = (drain_cnt == DRAIN_MAX);

   // Lowest set bit wins; ERET only when no real exception is pending.
   always_comb begin
      ev_eret   = 1'b0;
      ev_code   = 5'h00;
      ev_bav_we = 1'b0;
      ev_bav    = 32'h0;
      if (bus.exc_type_i[0]) begin
         ev_code = 5'h00;
      end else if (bus.exc_type_i[1]) begin
         ev_code   = 5'h04;
         ev_bav_we = 1'b1;
         ev_bav    = bus.exc_pc_i;
      end else if (bus.exc_type_i[2]) begin
         ev_code = 5'h0A;
      end else if (bus.exc_type_i[3]) begin
         ev_code = 5'h08;
      end else if (bus.exc_type_i[4]) begin
         ev_code = 5'h09;
      end else if (bus.exc_type_i[5]) begin
         ev_code = 5'h0C;
      end else if (bus.exc_type_i[6]) begin
         ev_code   = 5'h05;
         ev_bav_we = 1'b1;
         ev_bav    = bus.exc_memaddr_i;
      end else if (bus.exc_type_i[7]) begin
         ev_code   = 5'h04;
         ev_bav_we = 1'b1;
         ev_bav    = bus.exc_memaddr_i;
      end else if (bus.exc_type_i[8]) begin
         ev_eret = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (ev_any) state_nxt = DRAIN;
         DRAIN:    if (bus_idle || drain_expired) state_nxt = COMMIT;
         COMMIT:   state_nxt = REDIRECT;
         REDIRECT: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Capture, drain counter, sticky timeout and the redirect target sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cnt     <= 8'd0;
         drain_timeout <= 1'b0;
         redirect_pc   <= 32'h0;
         cap_eret      <= 1'b0;
         cap_epc       <= 32'h0;
         cap_bd        <= 1'b0;
         cap_code      <= 5'h00;
         cap_bav_we    <= 1'b0;
         cap_bav       <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               drain_cnt <= 8'd0;
               if (ev_any) begin
                  cap_eret   <= ev_eret;
                  cap_epc    <= ev_epc;
                  cap_bd     <= bus.exc_ds_i;
                  cap_code   <= ev_code;
                  cap_bav_we <= ev_bav_we;
                  cap_bav    <= ev_bav;
               end
            end
            DRAIN: begin
               if (!bus_idle) begin
                  if (drain_expired) begin
                     drain_timeout <= 1'b1;
                  end else begin
                     drain_cnt <= drain_cnt + 8'd1;
                  end
               end
            end
            COMMIT: begin
               redirect_pc <= cap_eret ? bus.cp0_epc_i : EXC_VECTOR;
            end
            default: begin
            end
         endcase
      end
   end

   logic [3:0] flush;
   logic       stall;
   logic       exc_we;
   logic       eret_pulse;
   logic       bav_we;
   logic       redirect_valid;
   logic       busy;

   always_comb begin
      flush          = 4'h0;
      stall          = 1'b0;
      exc_we         = 1'b0;
      eret_pulse     = 1'b0;
      bav_we         = 1'b0;
      redirect_valid = 1'b0;
      busy           = 1'b0;
      case (state)
         DRAIN: begin
            flush = 4'hF;
            stall = 1'b1;
            busy  = 1'b1;
         end
         COMMIT: begin
            stall      = 1'b1;
            busy       = 1'b1;
            exc_we     = !cap_eret;
            eret_pulse = cap_eret;
            bav_we     = !cap_eret && cap_bav_we;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            busy           = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.flush_o           = flush;
   assign bus.stall_o           = stall;
   assign bus.cp0_exc_we_o      = exc_we;
   assign bus.cp0_eret_o        = eret_pulse;
   assign bus.cp0_epc_o         = cap_epc;
   assign bus.cp0_bd_o          = cap_bd;
   assign bus.cp0_exccode_o     = cap_code;
   assign bus.cp0_badvaddr_we_o = bav_we;
   assign bus.cp0_badvaddr_o    = cap_bav;
   assign bus.redirect_valid_o  = redirect_valid;
   assign bus.redirect_pc_o     = redirect_pc;
   assign bus.drain_timeout_o   = drain_timeout;
   assign bus.busy_o            = busy;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb/tb_exc_redirect_ctrl.sv - directed self-checking bench for exc_redirect_ctrl
module tb_exc_redirect_ctrl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   exc_redirect_ctrl_if bus ();

   exc_redirect_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   // Fires one event, steers the bus-busy inputs through DRAIN, then checks commit and redirect.
   task automatic exc_seq(
      input string       tag,
      input logic [8:0]  typ,
      input logic [31:0] pc,
      input logic        ds,
      input logic [31:0] mem,
      input int          busy_n,
      input logic        stuck,
      input logic        inject,
      input int          exp_drain,
      input logic        exp_eret,
      input logic [4:0]  exp_code,
      input logic [31:0] exp_epc,
      input logic        exp_bd,
      input logic        exp_bav_we,
      input logic [31:0] exp_bav,
      input logic [31:0] exp_rpc
   );
      int drain;
      @(negedge clk);
      bus.exc_type_i    = typ;
      bus.exc_pc_i      = pc;
      bus.exc_ds_i      = ds;
      bus.exc_memaddr_i = mem;
      @(negedge clk);
      bus.exc_type_i = 9'h0;
      check({tag, "_drain_flush"}, {28'h0, bus.flush_o}, 32'hF);
      check({tag, "_drain_stall"}, {31'h0, bus.stall_o}, 32'h1);
      drain = 0;
      while (bus.flush_o == 4'hF && drain < 400) begin
         drain++;
         bus.dbus_busy_i = (drain <= busy_n);
         bus.ibus_busy_i = stuck;
         if (inject && drain == 3) bus.exc_type_i = 9'h008;
         @(negedge clk);
      end
      bus.dbus_busy_i = 1'b0;
      bus.ibus_busy_i = 1'b0;
      bus.exc_type_i  = 9'h0;
      check({tag, "_drain_len"}, drain, exp_drain);
      check({tag, "_commit_flush"}, {28'h0, bus.flush_o}, 32'h0);
      check({tag, "_commit_stall"}, {31'h0, bus.stall_o}, 32'h1);
      check({tag, "_exc_we"}, {31'h0, bus.cp0_exc_we_o}, {31'h0, !exp_eret});
      check({tag, "_eret"}, {31'h0, bus.cp0_eret_o}, {31'h0, exp_eret});
      check({tag, "_bav_we"}, {31'h0, bus.cp0_badvaddr_we_o}, {31'h0, exp_bav_we});
      if (!exp_eret) begin
         check({tag, "_exccode"}, {27'h0, bus.cp0_exccode_o}, {27'h0, exp_code});
         check({tag, "_epc"}, bus.cp0_epc_o, exp_epc);
         check({tag, "_bd"}, {31'h0, bus.cp0_bd_o}, {31'h0, exp_bd});
      end
      if (exp_bav_we) check({tag, "_badvaddr"}, bus.cp0_badvaddr_o, exp_bav);
      @(negedge clk);
      check({tag, "_redir_valid"}, {31'h0, bus.redirect_valid_o}, 32'h1);
      check({tag, "_redir_pc"}, bus.redirect_pc_o, exp_rpc);
      check({tag, "_redir_stall"}, {31'h0, bus.stall_o}, 32'h0);
      @(negedge clk);
      check({tag, "_idle_busy"}, {31'h0, bus.busy_o}, 32'h0);
      check({tag, "_idle_redir"}, {31'h0, bus.redirect_valid_o}, 32'h0);
   endtask

   initial begin
      logic saw_pulse;
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      bus.exc_type_i    = 9'h0;
      bus.exc_pc_i      = 32'h0;
      bus.exc_ds_i      = 1'b0;
      bus.exc_memaddr_i = 32'h0;
      bus.cp0_epc_i     = 32'h0;
      bus.ibus_busy_i   = 1'b0;
      bus.dbus_busy_i   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_flush", {28'h0, bus.flush_o}, 32'h0);
      check("rst_stall", {31'h0, bus.stall_o}, 32'h0);
      check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
      check("rst_epc", bus.cp0_epc_o, 32'h0);
      check("rst_redir_pc", bus.redirect_pc_o, 32'h0);
      check("rst_timeout", {31'h0, bus.drain_timeout_o}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_event", {31'h0, bus.busy_o}, 32'h0);

      exc_seq("sys", 9'h008, 32'h8000_1000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h08, 32'h8000_1000, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380);
      exc_seq("ov_ds", 9'h020, 32'h8000_0004, 1'b1, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h0C, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'hBFC0_0380);
      exc_seq("ov_wrap", 9'h020, 32'h0000_0000, 1'b1, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h0C, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 32'hBFC0_0380);
      exc_seq("adel_mem", 9'h080, 32'h8000_3000, 1'b0, 32'h1234_5671, 5, 1'b0, 1'b0, 6,
              1'b0, 5'h04, 32'h8000_3000, 1'b0, 1'b1, 32'h1234_5671, 32'hBFC0_0380);
      check("adel_mem_timeout", {31'h0, bus.drain_timeout_o}, 32'h0);
      exc_seq("ades_mem", 9'h040, 32'h8000_3004, 1'b0, 32'h0000_0102, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h05, 32'h8000_3004, 1'b0, 1'b1, 32'h0000_0102, 32'hBFC0_0380);
      exc_seq("adel_if", 9'h002, 32'h8000_0123, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h04, 32'h8000_0123, 1'b0, 1'b1, 32'h8000_0123, 32'hBFC0_0380);
      bus.cp0_epc_i = 32'h8000_2000;
      exc_seq("eret", 9'h100, 32'h8000_4000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b1, 5'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8000_2000);
      exc_seq("int_eret", 9'h101, 32'h8000_5000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h00, 32'h8000_5000, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380);
      exc_seq("bp_over_ades", 9'h050, 32'h8000_6000, 1'b0, 32'h0000_0203, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h09, 32'h8000_6000, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380);

      // ibus stuck: 256 DRAIN cycles (counter 0..255), syscall injected mid-drain is ignored.
      exc_seq("ri_stuck", 9'h004, 32'h8000_7000, 1'b0, 32'h0, 0, 1'b1, 1'b1, 256,
              1'b0, 5'h0A, 32'h8000_7000, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380);
      check("stuck_timeout", {31'h0, bus.drain_timeout_o}, 32'h1);
      exc_seq("after_stuck", 9'h008, 32'h8000_8000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1,
              1'b0, 5'h08, 32'h8000_8000, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380);
      check("timeout_held", {31'h0, bus.drain_timeout_o}, 32'h1);

      @(negedge clk);
      bus.exc_type_i  = 9'h008;
      bus.exc_pc_i    = 32'h8000_9000;
      bus.exc_ds_i    = 1'b0;
      bus.dbus_busy_i = 1'b1;
      @(negedge clk);
      bus.exc_type_i = 9'h0;
      check("rstdrain_flush", {28'h0, bus.flush_o}, 32'hF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstdrain_flush0", {28'h0, bus.flush_o}, 32'h0);
      check("rstdrain_stall0", {31'h0, bus.stall_o}, 32'h0);
      check("rstdrain_busy0", {31'h0, bus.busy_o}, 32'h0);
      check("rstdrain_epc0", bus.cp0_epc_o, 32'h0);
      check("rstdrain_code0", {27'h0, bus.cp0_exccode_o}, 32'h0);
      check("rstdrain_rpc0", bus.redirect_pc_o, 32'h0);
      check("rstdrain_timeout0", {31'h0, bus.drain_timeout_o}, 32'h0);
      rst = 1'b0;
      bus.dbus_busy_i = 1'b0;
      saw_pulse = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.cp0_exc_we_o || bus.cp0_eret_o || bus.redirect_valid_o) saw_pulse = 1'b1;
      end
      check("rstdrain_no_pulse", {31'h0, saw_pulse}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
